// File: rtl/mouse_axis_pkg.sv
// Shared definitions for the mouse-to-analog-axis emulator: FSM states,
// PS/2 mouse word field positions and the digital joystick word width.
package mouse_axis_pkg;

    typedef enum logic [1:0] {
        ST_PASS     = 2'd0,
        ST_MOUSE    = 2'd1,
        ST_RECENTER = 2'd2
    } state_t;

    // Field positions inside the 25-bit hps_io mouse word
    localparam int STB     = 24;
    localparam int YSGN    = 5;
    localparam int XSGN    = 4;
    localparam int X_LSB   = 8;
    localparam int Y_LSB   = 16;
    localparam int BTN_LSB = 0;

    // Digital joystick word width per port
    localparam int JOYD_W  = 21;

endpackage

// File: rtl/axis_accum.sv
// One saturating absolute axis: sign-extends a raw PS/2 delta, scales it
// down, clamps the per-packet step, then adds (or subtracts) it with
// saturation. Also supports a synchronous clear and a 1-LSB recentre step.
module axis_accum #(
    parameter int AXIS_W    = 8,
    parameter int DIV_SHIFT = 1,
    parameter int MAX_STEP  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_mag,
    input  logic              i_sign,
    input  logic              i_load,
    input  logic              i_invert,
    input  logic              i_clear,
    input  logic              i_step,
    output logic [AXIS_W-1:0] o_acc
);
    localparam int SW = AXIS_W + 2;
    localparam logic signed [31:0]   CLAMP  = MAX_STEP;
    localparam logic signed [SW-1:0] SAT_HI = {3'b000, {(AXIS_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {3'b111, {(AXIS_W-1){1'b0}}};

    logic [9:0]               w_raw;
    logic signed [31:0]       w_ext;
    logic signed [31:0]       w_shift;
    logic signed [31:0]       w_lim;
    logic [31-SW:0]           w_unused_hi;
    logic signed [SW-1:0]     w_dlt;
    logic signed [SW-1:0]     w_acc;
    logic signed [SW-1:0]     w_sum;
    logic [AXIS_W-1:0]        w_sat;
    logic [AXIS_W-1:0]        r_acc;

    // PS/2 delta is a 9-bit two's complement value; widen to 10 then 32 bits
    assign w_raw       = {i_sign, i_sign, i_mag};
    assign w_ext       = {{22{w_raw[9]}}, w_raw};
    assign w_shift     = w_ext >>> DIV_SHIFT;
    assign w_dlt       = w_lim[SW-1:0];
    assign w_unused_hi = w_lim[31:SW];
    assign w_acc       = {{2{r_acc[AXIS_W-1]}}, r_acc};
    assign w_sum       = i_invert ? (w_acc - w_dlt) : (w_acc + w_dlt);

    // Clamp the scaled delta, then saturate the widened sum to the axis range
    always_comb begin
        w_lim = w_shift;
        if (w_shift > CLAMP)
            w_lim = CLAMP;
        else if (w_shift < -CLAMP)
            w_lim = -CLAMP;
        w_sat = w_sum[AXIS_W-1:0];
        if (w_sum > SAT_HI)
            w_sat = SAT_HI[AXIS_W-1:0];
        else if (w_sum < SAT_LO)
            w_sat = SAT_LO[AXIS_W-1:0];
    end

    // Clear beats a new packet, which beats the recentre decay
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_load)
            r_acc <= w_sat;
        else if (i_step && (r_acc != '0))
            r_acc <= r_acc[AXIS_W-1] ? (r_acc + 1'b1) : (r_acc - 1'b1);
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-axis emulator. PS/2 mouse packets drive saturating X/Y
// positions on one selectable controller port; otherwise the real sticks
// pass through. Optional macro MOUSE_RECENTER_EN adds an idle timeout that
// slowly walks both axes back to centre.
module mouse_axis_emu
    import mouse_axis_pkg::*;
#(
    parameter int AXIS_W       = 8,
    parameter int NUM_PORTS    = 4,
    parameter int DIV_SHIFT    = 1,
    parameter int MAX_STEP     = 10,
    parameter int IDLE_CYCLES  = 1 << 22,
    parameter int RECENTER_DIV = 1 << 14
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [24:0]                     PS2_MOUSE,
    input  logic [NUM_PORTS*2*AXIS_W-1:0]   JOYA,
    input  logic [NUM_PORTS*JOYD_W-1:0]     JOYD,
    input  logic [$clog2(NUM_PORTS)-1:0]    PORT_SEL,
    input  logic                            INVERT_Y,
    input  logic                            CPU_HALT,
    output logic [NUM_PORTS*2*AXIS_W-1:0]   AXIS_OUT,
    output logic [NUM_PORTS*JOYD_W-1:0]     JOYD_OUT,
    output logic                            MOUSE_ACTIVE
);
    localparam int PSW = $clog2(NUM_PORTS);
    localparam int PW  = 2 * AXIS_W;

    state_t                              r_state;
    logic                                r_primed;
    logic                                r_stb;
    logic                                r_active;
    logic                                w_pkt;
    logic                                w_exit;
    logic                                w_load;
    logic                                w_clr;
    logic                                w_step;
    logic [AXIS_W-1:0]                   w_acc_x;
    logic [AXIS_W-1:0]                   w_acc_y;
    logic [NUM_PORTS-1:0][PW-1:0]        w_joya;
    logic [NUM_PORTS-1:0][PW-1:0]        r_axis;
    logic [NUM_PORTS-1:0][JOYD_W-1:0]    w_joyd;
    logic [NUM_PORTS-1:0][JOYD_W-1:0]    r_joyd;
    logic                                w_unused;

    assign w_joya   = JOYA;
    assign w_joyd   = JOYD;
    assign w_unused = ^{PS2_MOUSE[7:6], PS2_MOUSE[3:2]};

    // A packet is a strobe toggle, but only once the strobe has been sampled
    assign w_pkt  = r_primed && (PS2_MOUSE[STB] != r_stb);
    // Real stick movement or a halted CPU hands the port back
    assign w_exit = CPU_HALT || (w_joya[PORT_SEL] != '0);
    assign w_load = w_pkt && !w_exit;
    assign w_clr  = (r_state != ST_PASS) && w_exit;

    // Strobe history; the first cycle after reset only primes it
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_primed <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_stb    <= PS2_MOUSE[STB];
        end
    end

`ifdef MOUSE_RECENTER_EN
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam int DW = $clog2(RECENTER_DIV);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RECENTER_DIV - 1);

    logic [IW-1:0] r_idle;
    logic [DW-1:0] r_div;

    // Idle timer in MOUSE, decay prescaler in RECENTER; any packet restarts both
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idle <= '0;
            r_div  <= '0;
        end else if ((r_state == ST_PASS) || w_pkt || w_exit) begin
            r_idle <= '0;
            r_div  <= '0;
        end else if (r_state == ST_MOUSE) begin
            r_div <= '0;
            if (r_idle != IDLE_LAST)
                r_idle <= r_idle + 1'b1;
        end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : (r_div + 1'b1);
        end
    end

    assign w_step = (r_state == ST_RECENTER) && (r_div == DIV_LAST);
`else
    localparam int unused_cfg = IDLE_CYCLES ^ RECENTER_DIV;
    assign w_step = 1'b0;
`endif

    // Mode FSM: exit has priority over a same-cycle packet
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_state <= ST_PASS;
        else if (w_exit)
            r_state <= ST_PASS;
        else if (w_pkt)
            r_state <= ST_MOUSE;
`ifdef MOUSE_RECENTER_EN
        else if ((r_state == ST_MOUSE) && (r_idle == IDLE_LAST))
            r_state <= ST_RECENTER;
`endif
    end

    axis_accum #(.AXIS_W(AXIS_W), .DIV_SHIFT(DIV_SHIFT), .MAX_STEP(MAX_STEP)) u_acc_x (
        .i_clk    (CLK),
        .i_rst_n  (RESET_N),
        .i_mag    (PS2_MOUSE[X_LSB +: 8]),
        .i_sign   (PS2_MOUSE[XSGN]),
        .i_load   (w_load),
        .i_invert (1'b0),
        .i_clear  (w_clr),
        .i_step   (w_step),
        .o_acc    (w_acc_x)
    );

    axis_accum #(.AXIS_W(AXIS_W), .DIV_SHIFT(DIV_SHIFT), .MAX_STEP(MAX_STEP)) u_acc_y (
        .i_clk    (CLK),
        .i_rst_n  (RESET_N),
        .i_mag    (PS2_MOUSE[Y_LSB +: 8]),
        .i_sign   (PS2_MOUSE[YSGN]),
        .i_load   (w_load),
        .i_invert (INVERT_Y),
        .i_clear  (w_clr),
        .i_step   (w_step),
        .o_acc    (w_acc_y)
    );

    // Output register: selected port shows the mouse while not in PASS
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_axis   <= '0;
            r_joyd   <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= (r_state != ST_PASS);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ((r_state != ST_PASS) && (PORT_SEL == PSW'(p))) begin
                    r_axis[p] <= {w_acc_y, w_acc_x};
                    r_joyd[p] <= {w_joyd[p][JOYD_W-1:6], PS2_MOUSE[BTN_LSB +: 2], w_joyd[p][3:0]};
                end else begin
                    r_axis[p] <= w_joya[p];
                    r_joyd[p] <= w_joyd[p];
                end
            end
        end
    end

    assign AXIS_OUT     = r_axis;
    assign JOYD_OUT     = r_joyd;
    assign MOUSE_ACTIVE = r_active;

endmodule

// File: tb/tb_mouse_axis_emu.sv
// Directed bench for mouse_axis_emu with hand-computed expectations.
// Honours MOUSE_RECENTER_EN for the idle/recentre expectation.
module tb_mouse_axis_emu;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [24:0] ps2;
    logic [63:0] joya;
    logic [83:0] joyd;
    logic [1:0]  port_sel;
    logic        invert_y;
    logic        cpu_halt;
    logic [63:0] axis_out;
    logic [83:0] joyd_out;
    logic        mouse_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mouse_axis_emu #(
        .AXIS_W(8), .NUM_PORTS(4), .DIV_SHIFT(1), .MAX_STEP(10),
        .IDLE_CYCLES(16), .RECENTER_DIV(4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PS2_MOUSE    (ps2),
        .JOYA         (joya),
        .JOYD         (joyd),
        .PORT_SEL     (port_sel),
        .INVERT_Y     (invert_y),
        .CPU_HALT     (cpu_halt),
        .AXIS_OUT     (axis_out),
        .JOYD_OUT     (joyd_out),
        .MOUSE_ACTIVE (mouse_active)
    );

    function automatic logic [15:0] ax(input int p);
        return axis_out[p*16 +: 16];
    endfunction

    function automatic logic [20:0] jd(input int p);
        return joyd_out[p*21 +: 21];
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pkt(input logic [7:0] x, input logic xs, input logic [7:0] y, input logic ys);
        ps2[24]    = ~ps2[24];
        ps2[23:16] = y;
        ps2[15:8]  = x;
        ps2[5]     = ys;
        ps2[4]     = xs;
        tick();
    endtask

    initial begin
        RESET_N  = 1'b0;
        ps2      = 25'h1000000;
        joya     = '0;
        joyd     = '0;
        port_sel = 2'd0;
        invert_y = 1'b0;
        cpu_halt = 1'b0;
        tick();
        tick();
        chk("reset_axis", axis_out, 64'h0);
        chk("reset_joyd", joyd_out, 84'h0);
        chk("reset_active", mouse_active, 1'b0);

        // Priming cycle with strobe held at 1: nothing moves
        RESET_N = 1'b1;
        tick();
        tick();
        tick();
        chk("prime_active", mouse_active, 1'b0);
        chk("prime_axis", ax(0), 16'h0000);

        // X=+20 -> >>1 = 10 -> accX = 10, visible two edges after toggle
        pkt(8'd20, 1'b0, 8'd0, 1'b0);
        chk("first_lat1", ax(0), 16'h0000);
        tick();
        chk("first_lat2", ax(0), 16'h000A);
        chk("first_active", mouse_active, 1'b1);

        // 20 back-to-back packets of -40 -> -10 each, saturate at -128
        for (int i = 0; i < 20; i++) pkt(8'hD8, 1'b1, 8'd0, 1'b0);
        tick();
        chk("sat_neg", ax(0), 16'h0080);

        // Inverted Y: +8 -> 4, subtracted -> accY = -4
        invert_y = 1'b1;
        pkt(8'd0, 1'b0, 8'd8, 1'b0);
        tick();
        chk("invert_y", ax(0), 16'hFC80);

        // Real stick on selected port -> PASS, accumulators cleared
        invert_y = 1'b0;
        joya[15:0] = 16'h0010;
        tick();
        tick();
        chk("stick_pass", ax(0), 16'h0010);
        chk("stick_inactive", mouse_active, 1'b0);
        joya[15:0] = 16'h0000;
        pkt(8'd2, 1'b0, 8'd0, 1'b0);
        tick();
        chk("acc_cleared", ax(0), 16'h0001);

        // Packet together with CPU_HALT: exit wins, delta discarded
        cpu_halt = 1'b1;
        pkt(8'd20, 1'b0, 8'd0, 1'b0);
        tick();
        chk("halt_axis", ax(0), 16'h0000);
        chk("halt_active", mouse_active, 1'b0);
        cpu_halt = 1'b0;
        pkt(8'd4, 1'b0, 8'd0, 1'b0);
        tick();
        chk("halt_acc_zero", ax(0), 16'h0002);

        // Build accX = 2+10+10+8 = 30, then move mouse to port 2
        pkt(8'd20, 1'b0, 8'd0, 1'b0);
        pkt(8'd20, 1'b0, 8'd0, 1'b0);
        pkt(8'd16, 1'b0, 8'd0, 1'b0);
        tick();
        chk("acc_30", ax(0), 16'h001E);
        port_sel  = 2'd2;
        joya      = {16'h0000, 16'h0000, 16'h5678, 16'h1234};
        joyd      = {21'h0, 21'h0F00CF, 21'h0, 21'h000030};
        ps2[1:0]  = 2'b11;
        tick();
        chk("sel_p0_pass", ax(0), 16'h1234);
        chk("sel_p1_pass", ax(1), 16'h5678);
        chk("sel_p2_mouse", ax(2), 16'h001E);
        chk("sel_p2_btn", jd(2), 21'h0F00FF);
        chk("sel_p0_joyd", jd(0), 21'h000030);

        // Exit via port 2 stick, then accX = +3 for the idle test
        joya[47:32] = 16'h0001;
        tick();
        tick();
        chk("p2_exit", ax(2), 16'h0001);
        joya[47:32] = 16'h0000;
        pkt(8'd6, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 28; i++) tick();
`ifdef MOUSE_RECENTER_EN
        chk("idle_e28", ax(2), 16'h0001);
        tick();
        chk("idle_e29", ax(2), 16'h0000);
`else
        chk("idle_e28", ax(2), 16'h0003);
        tick();
        chk("idle_e29", ax(2), 16'h0003);
`endif
        chk("idle_active", mouse_active, 1'b1);

        // Reset in the middle of a packet, then a toggle during re-priming
        joya = '0;
        ps2[24] = ~ps2[24];
        RESET_N = 1'b0;
        #1;
        chk("midrst_axis", axis_out, 64'h0);
        chk("midrst_active", mouse_active, 1'b0);
        tick();
        RESET_N = 1'b1;
        ps2[24] = ~ps2[24];
        tick();
        tick();
        chk("reprime_active", mouse_active, 1'b0);
        chk("reprime_axis", ax(2), 16'h0000);
        pkt(8'd20, 1'b0, 8'd0, 1'b0);
        tick();
        chk("after_reprime", ax(2), 16'h000A);
        chk("after_reprime_act", mouse_active, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
